// File: rtl/ad_pkg.sv
// Shared types and constants for the 16-bit word to byte unpacker
// and its test-ramp checker.
package ad_pkg;

  localparam logic [1:0] CH_SEL_CH1  = 2'b01;
  localparam logic [1:0] CH_SEL_CH2  = 2'b00;
  localparam logic [1:0] CH_SEL_TEST = 2'b10;

  localparam int TEST_RAMP_W = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BYTE0,
    S_BYTE1
  } state_t;

  function automatic logic [7:0] pick_byte(
    input logic [15:0] w,
    input logic        hi
  );
    return hi ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/ad_16bit_to_byte_unpack_if.sv
// Word-in / byte-out handshake bundle between the SDRAM read FIFO
// and the USB transmit FIFO.
interface ad_16bit_to_byte_unpack_if;

  logic [15:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;

  modport master (
    output word_in,
    output word_valid,
    output byte_ready,
    input  word_ready,
    input  byte_out,
    input  byte_valid
  );

  modport slave (
    input  word_in,
    input  word_valid,
    input  byte_ready,
    output word_ready,
    output byte_out,
    output byte_valid
  );

endinterface

// File: rtl/ad_ramp_checker.sv
// Test-ramp checker: {4'd0, ramp[9:0], 2'd0} with ramp stepping by one,
// sticky flag and saturating mismatch count.
module ad_ramp_checker
  import ad_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid,
  input  logic             unseed,
  input  logic [15:0]      word,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_flag
);

  logic [TEST_RAMP_W-1:0] prev;
  logic [TEST_RAMP_W-1:0] ramp;
  logic                   seeded;
  logic                   zero_bad;
  logic                   seq_bad;
  logic                   bad;

  assign ramp     = word[2 +: TEST_RAMP_W];
  assign zero_bad = (word[15:12] != 4'd0) ||
                    (word[1:0] != 2'd0);
  assign seq_bad  = seeded &&
                    (ramp != prev + TEST_RAMP_W'(1));
  assign bad      = zero_bad || seq_bad;

  // A clear coinciding with a word discards its verdict but keeps it as seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= '0;
      seeded   <= 1'b0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (clear) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
      seeded   <= valid;
      if (valid)
        prev <= ramp;
    end else if (valid) begin
      prev   <= ramp;
      seeded <= 1'b1;
      if (bad) begin
        err_flag <= 1'b1;
        if (err_cnt != '1)
          err_cnt <= err_cnt + ERR_W'(1);
      end
    end else if (unseed) begin
      seeded <= 1'b0;
    end
  end

endmodule

// File: rtl/ad_16bit_to_byte_unpack.sv
// Serialises 16-bit SDRAM read words into USB bytes: one byte per
// word in channel modes, both bytes plus ramp checking in test mode.
module ad_16bit_to_byte_unpack
  import ad_pkg::*;
#(
  parameter bit HI_FIRST = 1'b0,
  parameter int ERR_W    = 16,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             ch_sel,
  input  logic                   chk_clear,
  ad_16bit_to_byte_unpack_if.slave bus,
  output logic [ERR_W-1:0]       err_cnt,
  output logic                   err_flag,
  output logic [CNT_W-1:0]       word_cnt
);

  state_t      state;
  state_t      state_d;
  logic [15:0] word_q;
  logic        test_q;
  logic        accept;
  logic        is_test;
  logic        word_ready_d;
  logic        byte_valid_d;
  logic [7:0]  byte_out_d;

  assign accept  = bus.word_valid && bus.word_ready;
  assign is_test = (ch_sel == CH_SEL_TEST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d      = state;
    word_ready_d = 1'b0;
    byte_valid_d = bus.byte_valid;
    byte_out_d   = bus.byte_out;
    unique case (state)
      S_IDLE: begin
        word_ready_d = 1'b1;
        if (accept) begin
          state_d      = S_BYTE0;
          word_ready_d = 1'b0;
          byte_valid_d = 1'b1;
          byte_out_d   = pick_byte(bus.word_in,
                                   is_test && HI_FIRST);
        end
      end
      S_BYTE0: begin
        if (bus.byte_ready) begin
          if (test_q) begin
            state_d    = S_BYTE1;
            byte_out_d = pick_byte(word_q, !HI_FIRST);
          end else begin
            state_d      = S_IDLE;
            word_ready_d = 1'b1;
            byte_valid_d = 1'b0;
          end
        end
      end
      S_BYTE1: begin
        if (bus.byte_ready) begin
          state_d      = S_IDLE;
          word_ready_d = 1'b1;
          byte_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // word_ready is registered so it stays low for the first cycle out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.word_ready <= 1'b0;
      bus.byte_valid <= 1'b0;
      bus.byte_out   <= '0;
      word_q         <= '0;
      test_q         <= 1'b0;
      word_cnt       <= '0;
    end else begin
      bus.word_ready <= word_ready_d;
      bus.byte_valid <= byte_valid_d;
      bus.byte_out   <= byte_out_d;
      if (accept) begin
        word_q   <= bus.word_in;
        test_q   <= is_test;
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

  ad_ramp_checker #(
    .ERR_W (ERR_W)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .clear    (chk_clear),
    .valid    (accept && is_test),
    .unseed   (accept && !is_test),
    .word     (bus.word_in),
    .err_cnt  (err_cnt),
    .err_flag (err_flag)
  );

endmodule

// File: tb/tb_ad_16bit_to_byte_unpack.sv
// Directed bench: table of words with expected bytes and error state,
// plus hand sequences for clear, stalls, saturation and async reset.
module tb_ad_16bit_to_byte_unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ch_sel_a = 2'b00;
  logic [1:0]  ch_sel_b = 2'b00;
  logic        chk_clear_a = 1'b0;
  logic        chk_clear_b = 1'b0;
  logic [15:0] err_cnt_a;
  logic        err_flag_a;
  logic [31:0] word_cnt_a;
  logic [1:0]  err_cnt_b;
  logic        err_flag_b;
  logic [31:0] word_cnt_b;

  ad_16bit_to_byte_unpack_if bus_a ();
  ad_16bit_to_byte_unpack_if bus_b ();

  ad_16bit_to_byte_unpack #(
    .HI_FIRST (1'b0),
    .ERR_W    (16),
    .CNT_W    (32)
  ) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .ch_sel    (ch_sel_a),
    .chk_clear (chk_clear_a),
    .bus       (bus_a),
    .err_cnt   (err_cnt_a),
    .err_flag  (err_flag_a),
    .word_cnt  (word_cnt_a)
  );

  ad_16bit_to_byte_unpack #(
    .HI_FIRST (1'b1),
    .ERR_W    (2),
    .CNT_W    (32)
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .ch_sel    (ch_sel_b),
    .chk_clear (chk_clear_b),
    .bus       (bus_b),
    .err_cnt   (err_cnt_b),
    .err_flag  (err_flag_b),
    .word_cnt  (word_cnt_b)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int wc       = 0;
  logic rdy_rand = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk)
    bus_a.byte_ready = rdy_rand ?
      1'($urandom_range(0, 1)) : 1'b1;

  logic       held_v = 1'b0;
  logic [7:0] held_b = 8'h00;
  logic [7:0] exp_b;

  // Byte monitor: ordering, stall stability, busy => not ready
  always @(negedge clk) begin
    #1;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("stall_valid", 32'(bus_a.byte_valid), 1);
        check("stall_byte", 32'(bus_a.byte_out),
              32'(held_b));
      end
      if (bus_a.byte_valid)
        check("busy_not_ready", 32'(bus_a.word_ready), 0);
      held_v = 1'b0;
      if (bus_a.byte_valid && bus_a.byte_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", 32'(bus_a.byte_out), 32'hFFFF);
        end else begin
          exp_b = exp_q.pop_front();
          check("byte", 32'(bus_a.byte_out), 32'(exp_b));
        end
      end else if (bus_a.byte_valid) begin
        held_v = 1'b1;
        held_b = bus_a.byte_out;
      end
    end
  end

  task automatic send(input logic [1:0] ch,
                      input logic [15:0] w,
                      input logic clr,
                      input int nb,
                      input logic [7:0] b0,
                      input logic [7:0] b1);
    logic ok;
    ok = 1'b0;
    ch_sel_a         = ch;
    bus_a.word_in    = w;
    bus_a.word_valid = 1'b1;
    chk_clear_a      = clr;
    exp_q.push_back(b0);
    if (nb == 2)
      exp_q.push_back(b1);
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus_a.word_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus_a.word_valid = 1'b0;
    chk_clear_a      = 1'b0;
    if (ok)
      wc++;
    else
      check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && bus_a.word_ready &&
          !bus_a.byte_valid) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("drain", 32'(done), 1);
  endtask

  task automatic accept_b();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus_b.word_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus_b.word_valid = 1'b0;
    if (!ok)
      check("b_accept_timeout", 0, 1);
  endtask

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] word;
    int          nb;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] err;
    logic        flag;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{2'b01, 16'h00A5, 1, 8'hA5, 8'h00, 16'd0, 1'b0};
    vecs[1]  = '{2'b01, 16'h005A, 1, 8'h5A, 8'h00, 16'd0, 1'b0};
    vecs[2]  = '{2'b10, 16'h0FF0, 2, 8'hF0, 8'h0F, 16'd0, 1'b0};
    vecs[3]  = '{2'b10, 16'h0FF4, 2, 8'hF4, 8'h0F, 16'd0, 1'b0};
    vecs[4]  = '{2'b10, 16'h0FF8, 2, 8'hF8, 8'h0F, 16'd0, 1'b0};
    vecs[5]  = '{2'b10, 16'h0FFC, 2, 8'hFC, 8'h0F, 16'd0, 1'b0};
    vecs[6]  = '{2'b10, 16'h0000, 2, 8'h00, 8'h00, 16'd0, 1'b0};
    vecs[7]  = '{2'b10, 16'h0004, 2, 8'h04, 8'h00, 16'd0, 1'b0};
    vecs[8]  = '{2'b00, 16'h1234, 1, 8'h34, 8'h00, 16'd0, 1'b0};
    vecs[9]  = '{2'b10, 16'h0014, 2, 8'h14, 8'h00, 16'd0, 1'b0};
    vecs[10] = '{2'b10, 16'h0018, 2, 8'h18, 8'h00, 16'd0, 1'b0};
    vecs[11] = '{2'b10, 16'h0020, 2, 8'h20, 8'h00, 16'd1, 1'b1};
    vecs[12] = '{2'b10, 16'h0024, 2, 8'h24, 8'h00, 16'd1, 1'b1};
    vecs[13] = '{2'b10, 16'h8024, 2, 8'h24, 8'h80, 16'd2, 1'b1};
    vecs[14] = '{2'b11, 16'hABCD, 1, 8'hCD, 8'h00, 16'd2, 1'b1};
    vecs[15] = '{2'b01, 16'hFF77, 1, 8'h77, 8'h00, 16'd2, 1'b1};

    bus_a.word_in    = '0;
    bus_a.word_valid = 1'b0;
    bus_b.word_in    = '0;
    bus_b.word_valid = 1'b0;
    bus_b.byte_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_word_ready", 32'(bus_a.word_ready), 0);
    check("rst_byte_valid", 32'(bus_a.byte_valid), 0);
    check("rst_byte_out", 32'(bus_a.byte_out), 0);
    check("rst_err_cnt", 32'(err_cnt_a), 0);
    check("rst_err_flag", 32'(err_flag_a), 0);
    check("rst_word_cnt", word_cnt_a, 0);
    rst = 1'b0;
    #1;
    check("ready_low_after_rst", 32'(bus_a.word_ready), 0);
    @(negedge clk);
    check("ready_rise", 32'(bus_a.word_ready), 1);

    // Table: channel, test ramp with wrap, errors and re-sync
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].ch, vecs[i].word, 1'b0,
           vecs[i].nb, vecs[i].b0, vecs[i].b1);
      check($sformatf("tbl%0d_err_cnt", i),
            32'(err_cnt_a), 32'(vecs[i].err));
      check($sformatf("tbl%0d_err_flag", i),
            32'(err_flag_a), 32'(vecs[i].flag));
      check($sformatf("tbl%0d_word_cnt", i),
            word_cnt_a, 32'(wc));
    end
    drain();

    // Clear coincident with a bad word: clear wins, word seeds
    send(2'b10, 16'h8040, 1'b1, 2, 8'h40, 8'h80);
    check("clr_err_cnt", 32'(err_cnt_a), 0);
    check("clr_err_flag", 32'(err_flag_a), 0);
    send(2'b10, 16'h0044, 1'b0, 2, 8'h44, 8'h00);
    check("after_clr_seq", 32'(err_cnt_a), 0);
    send(2'b10, 16'h004C, 1'b0, 2, 8'h4C, 8'h00);
    check("seeded_gap_err", 32'(err_cnt_a), 1);
    check("seeded_gap_flag", 32'(err_flag_a), 1);
    drain();
    chk_clear_a = 1'b1;
    @(negedge clk);
    chk_clear_a = 1'b0;
    check("pulse_clr_cnt", 32'(err_cnt_a), 0);
    check("pulse_clr_flag", 32'(err_flag_a), 0);

    // ch_sel change mid-word leaves bytes in flight intact
    send(2'b10, 16'h0048, 1'b0, 2, 8'h48, 8'h00);
    ch_sel_a = 2'b01;
    drain();
    check("midword_err", 32'(err_cnt_a), 0);

    // Random backpressure with words presented back to back
    rdy_rand = 1'b1;
    send(2'b10, 16'h004C, 1'b0, 2, 8'h4C, 8'h00);
    send(2'b01, 16'h1122, 1'b0, 1, 8'h22, 8'h00);
    send(2'b10, 16'h0100, 1'b0, 2, 8'h00, 8'h01);
    send(2'b10, 16'h0104, 1'b0, 2, 8'h04, 8'h01);
    send(2'b00, 16'h00EE, 1'b0, 1, 8'hEE, 8'h00);
    send(2'b11, 16'h7799, 1'b0, 1, 8'h99, 8'h00);
    send(2'b10, 16'h0200, 1'b0, 2, 8'h00, 8'h02);
    drain();
    rdy_rand = 1'b0;
    check("rand_err_cnt", 32'(err_cnt_a), 0);
    check("rand_word_cnt", word_cnt_a, 32'(wc));

    // Second instance: high byte first, 2-bit counter saturation
    ch_sel_b = 2'b10;
    for (int i = 0; i < 5; i++) begin
      bus_b.word_in    = 16'hF000;
      bus_b.word_valid = 1'b1;
      accept_b();
      check($sformatf("sat%0d_err_cnt", i),
            32'(err_cnt_b), (i < 3) ? i + 1 : 3);
      check("sat_err_flag", 32'(err_flag_b), 1);
      check("hi_first_b0", 32'(bus_b.byte_out), 32'hF0);
      @(negedge clk);
      check("hi_first_b1", 32'(bus_b.byte_out), 32'h00);
      check("hi_first_v", 32'(bus_b.byte_valid), 1);
      @(negedge clk);
    end

    // Stall in S_BYTE1 then async reset mid-cycle
    bus_b.word_in    = 16'hF000;
    bus_b.word_valid = 1'b1;
    accept_b();
    @(negedge clk);
    bus_b.byte_ready = 1'b0;
    check("b1_stall_byte", 32'(bus_b.byte_out), 32'h00);
    @(negedge clk);
    check("b1_stall_hold", 32'(bus_b.byte_out), 32'h00);
    check("b1_stall_valid", 32'(bus_b.byte_valid), 1);
    check("sat_hold", 32'(err_cnt_b), 3);
    check("b_word_cnt", word_cnt_b, 6);
    #2 rst = 1'b1;
    #1;
    check("arst_b_valid", 32'(bus_b.byte_valid), 0);
    check("arst_b_byte", 32'(bus_b.byte_out), 0);
    check("arst_b_ready", 32'(bus_b.word_ready), 0);
    check("arst_b_err", 32'(err_cnt_b), 0);
    check("arst_b_flag", 32'(err_flag_b), 0);
    check("arst_b_cnt", word_cnt_b, 0);
    check("arst_a_cnt", word_cnt_a, 0);
    @(negedge clk);
    rst = 1'b0;
    bus_b.byte_ready = 1'b1;
    wc = 0;
    @(negedge clk);
    check("rerelease_a_ready", 32'(bus_a.word_ready), 1);
    check("rerelease_b_ready", 32'(bus_b.word_ready), 1);
    check("rerelease_b_valid", 32'(bus_b.byte_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
